// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: linear frequency-sweep controller for the lpm_nco phase increment.
// Steps phi_inc_o from start_inc toward stop_inc by step_inc, holding each value
// for dwell+1 clocks. The sweep is either single-shot or repeating.
//
// Ports:
//   clk          NCO clock; all logic is rising-edge
//   reset_n      asynchronous active-low reset
//   start        level; begins a sweep when sampled in IDLE
//   abort        level; ends any sweep and zeroes phi_inc_o; highest priority
//   repeat_en    1 = reload start_inc after the end, 0 = single-shot (sampled with start)
//   start_inc    first increment (sampled with start)
//   stop_inc     unsigned upper bound (sampled with start)
//   step_inc     unsigned increment added per step (sampled with start)
//   dwell        each value is held dwell+1 cycles (sampled with start)
//   phi_inc_o    registered increment to NCO phi_inc_i
//   inc_update   1-cycle strobe when phi_inc_o is loaded
//   busy         high while sweeping
//   done         1-cycle strobe at single-shot completion
//   wrap         1-cycle strobe when a repeating sweep reloads start_inc
module nco_sweep_ctrl #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               repeat_en,
    input  logic [PHASE_W-1:0] start_inc,
    input  logic [PHASE_W-1:0] stop_inc,
    input  logic [PHASE_W-1:0] step_inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic [PHASE_W-1:0] phi_inc_o,
    output logic               inc_update,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sweep configuration captured when a sweep starts.
    typedef struct packed {
        logic [PHASE_W-1:0] start_v;
        logic [PHASE_W-1:0] stop_v;
        logic [PHASE_W-1:0] step_v;
        logic [DWELL_W-1:0] dwell_v;
        logic               rpt;
    } cfg_t;

    state_t             state_q, state_d;
    cfg_t               cfg_q, cfg_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [PHASE_W-1:0] phi_d;
    logic               upd_d, busy_d, done_d, wrap_d;

    // One extra bit keeps the carry so an overflowing step counts as past stop.
    logic [PHASE_W:0] next_c;
    logic             in_range_c;

    assign next_c     = {1'b0, phi_inc_o} + {1'b0, cfg_q.step_v};
    assign in_range_c = (next_c <= {1'b0, cfg_q.stop_v});

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            phi_inc_o  <= '0;
            inc_update <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            phi_inc_o  <= phi_d;
            inc_update <= upd_d;
            busy       <= busy_d;
            done       <= done_d;
            wrap       <= wrap_d;
        end
    end

    // Next-state and next-output logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        phi_d   = phi_inc_o;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            phi_d   = '0;
            upd_d   = (phi_inc_o != '0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cfg_d.start_v = start_inc;
                        cfg_d.stop_v  = stop_inc;
                        cfg_d.step_v  = step_inc;
                        cfg_d.dwell_v = dwell;
                        cfg_d.rpt     = repeat_en;
                        phi_d         = start_inc;
                        upd_d         = 1'b1;
                        cnt_d         = dwell;
                        state_d       = RUN;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (in_range_c) begin
                        phi_d = next_c[PHASE_W-1:0];
                        upd_d = 1'b1;
                        cnt_d = cfg_q.dwell_v;
                    end else if (cfg_q.rpt) begin
                        phi_d  = cfg_q.start_v;
                        upd_d  = 1'b1;
                        wrap_d = 1'b1;
                        cnt_d  = cfg_q.dwell_v;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN);
    end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep controller that drives the 32-bit phase-increment input of an `lpm_nco` instance. On command it steps the increment linearly from a start value to a stop value, holding each value for a programmable dwell time. It runs either single-shot or continuously repeating. It sits directly upstream of the NCO in the `CLK_125` domain and replaces a static `phi_inc_i` tie-off, so the NCO/adder chain can be exercised with chirps instead of fixed tones.

## Interface
- `PHASE_W`, 32, width of phase increment (matches NCO `phi_inc_i`)
- `DWELL_W`, 16, width of dwell counter
- `clk` in 1 — NCO clock (`CLK_125`); all logic rising-edge
- `reset_n` in 1 — asynchronous, active-low reset
- `start` in 1 — level; sampled only in IDLE; begins a sweep
- `abort` in 1 — level; terminates any sweep, highest priority
- `repeat_en` in 1 — sampled with `start`; 1 = restart at start value after end, 0 = single-shot
- `start_inc` in PHASE_W — first increment; sampled with `start`
- `stop_inc` in PHASE_W — upper bound (unsigned); sampled with `start`
- `step_inc` in PHASE_W — added per step (unsigned); sampled with `start`
- `dwell` in DWELL_W — each value is held `dwell+1` cycles; sampled with `start`
- `phi_inc_o` out PHASE_W — to NCO `phi_inc_i`
- `inc_update` out 1 — 1-cycle strobe when `phi_inc_o` takes a new value
- `busy` out 1 — high in RUN
- `done` out 1 — 1-cycle strobe at single-shot completion
- `wrap` out 1 — 1-cycle strobe when a repeating sweep reloads `start_inc`

## Operation
- Reset values: `phi_inc_o`=0, `inc_update`=0, `busy`=0, `done`=0, `wrap`=0, state IDLE, all latched config 0.
- States: IDLE, RUN. `done`, `wrap` and `inc_update` are registered strobes, not states.
- IDLE: on `start`=1 (and `abort`=0):
  - latch `start_inc`, `stop_inc`, `step_inc`, `dwell`, `repeat_en`;
  - `phi_inc_o`<=`start_inc`, `inc_update`<=1, dwell counter<=`dwell`;
  - go to RUN.
- RUN: the counter decrements each cycle. Input changes are ignored; the latched copies are used.
- RUN, counter==0: form `next` = {1'b0,`phi_inc_o`} + {1'b0,step} (PHASE_W+1 bits).
  - If `next` <= {1'b0,stop}: `phi_inc_o`<=`next[PHASE_W-1:0]`, `inc_update`<=1, counter<=dwell.
  - Else (past stop, including carry-out), with repeat: `phi_inc_o`<=start, `inc_update`<=1, `wrap`<=1, counter<=dwell.
  - Else (past stop), single-shot: `phi_inc_o` holds its last value, `done`<=1, go to IDLE.
- `start_inc` > `stop_inc`: `start_inc` is still output for one dwell period, then the end condition fires (done or wrap).
- `step_inc`=0: the value never exceeds stop. The sweep holds `start_inc` until `abort`.
- `abort`=1 in any state: next cycle state IDLE, `phi_inc_o`<=0, `inc_update`<=1 if `phi_inc_o`≠0, no `done`/`wrap`. `abort` wins over a simultaneous `start`, step or end.
- `start` while in RUN: ignored.
- `start` held high through `done`: a new sweep begins on the first IDLE cycle, i.e. the cycle after `done`.
- Asynchronous reset mid-sweep: all outputs go to reset values immediately.

## Timing
- `start` sampled high at edge N: at N+1 `phi_inc_o`=`start_inc`, `busy`=1, `inc_update`=1.
- Each value is held exactly `dwell+1` cycles. Next update is at edge N+1+(`dwell+1`)·k.
- `done` is high and `busy` is low in the same cycle, one value-period after the last in-range value.
- `abort` sampled at edge M: `busy`=0 and `phi_inc_o`=0 at M+1.
- All outputs are registered; no combinational input-to-output paths.
- One adder (PHASE_W+1) and one comparator per cycle; closes at 125 MHz.

## Test plan
- Reset: hold `reset_n`=0, then release -> all outputs 0, `busy`=0; assert `reset_n` low mid-sweep -> outputs 0 asynchronously.
- Single-shot: start=0x100, stop=0x400, step=0x100, dwell=3 -> `phi_inc_o` = 0x100, 0x200, 0x300, 0x400, each 4 cycles, with 4 `inc_update` strobes; `done` 4 cycles after 0x400 appears; `phi_inc_o` stays 0x400.
- Repeat: same config with `repeat_en`=1, dwell=0 -> sequence 0x100..0x400 then 0x100 with `wrap`=1, period 4 cycles, no `done`.
- Overflow: start=0xFFFF_FF00, stop=0xFFFF_FFFF, step=0x80, dwell=0 -> 0xFFFF_FF00, 0xFFFF_FF80, then `done` (carry-out detected, no wrap to a small value).
- Abort priority: abort asserted on the same edge as a scheduled step -> next cycle `phi_inc_o`=0, `busy`=0, no `done`/`wrap`; `start` asserted during RUN -> no effect.
- Degenerate: `start_inc`=0x500 > `stop_inc`=0x400, dwell=2 -> 0x500 held 3 cycles, then `done`; `step_inc`=0 -> `start_inc` held for 1000 cycles until abort.
